// File: rtl/decoder24_seq_if.sv
// Handshake and decoded-output bundle for decoder24_seq.
// The master drives the code; the slave (the decoder) returns readiness and one-hot lines.
interface decoder24_seq_if;
    logic in_valid;
    logic in_ready;
    logic y0;
    logic y1;
    logic a0;
    logic a1;
    logic a2;
    logic a3;
    logic out_valid;

    modport master (
        output in_valid,
        output y0,
        output y1,
        input  in_ready,
        input  a0,
        input  a1,
        input  a2,
        input  a3,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  y0,
        input  y1,
        output in_ready,
        output a0,
        output a1,
        output a2,
        output a3,
        output out_valid
    );
endinterface

// File: rtl/decoder24_seq.sv
// Sequenced 2-to-4 decoder: each accepted code drives one line for HOLD_CYCLES, then GAP_CYCLES of zeros.
// Optional per-line saturating event counters are built when DECODER24_CNT_EN is defined.
module decoder24_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder24_seq_if.slave       bus,
    input  logic [1:0]           cnt_sel,
    output logic [7:0]           cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [1:0] code_q, code_d;
    logic [3:0] lines_q, lines_d;
    logic       out_valid_q, out_valid_d;
    logic       accept;
    logic [1:0] code_in;

    assign code_in      = {bus.y1, bus.y0};
    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && (state_q == IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        code_d      = code_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d     = code_in;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == 8'd0) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = GAP;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        out_valid_d = (state_d == HOLD);
        lines_d     = (state_d == HOLD) ? (4'b0001 << code_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= 8'd0;
            gap_cnt_q   <= 8'd0;
            code_q      <= 2'b00;
            lines_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            code_q      <= code_d;
            lines_q     <= lines_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.a0        = lines_q[0];
    assign bus.a1        = lines_q[1];
    assign bus.a2        = lines_q[2];
    assign bus.a3        = lines_q[3];
    assign bus.out_valid = out_valid_q;

`ifdef DECODER24_CNT_EN
    logic [7:0] cnt_q [4];

    always_ff @(posedge clk) begin
        // NOTE: the counter array is a handful of flops, not a RAM, so clearing it on reset is cheap and observable.
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else if (accept && (cnt_q[code_in] != 8'hFF)) begin
            cnt_q[code_in] <= cnt_q[code_in] + 8'd1;
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`else
    logic unused_cnt_sel;

    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = 8'd0;
`endif

endmodule

// File: doc/decoder24_seq.md
DECODER24_SEQ -- requirements
Module: decoder24_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, which sets the number of cycles a decoded one-hot output is held (legal 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, which sets the number of all-zero cycles inserted after each hold (legal 0..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: code present on y1,y0.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a code.
REQ-007 The block SHALL have ports y0 and y1, each input, 1 bit: 2-bit code (y1 is the MSB).
REQ-008 The block SHALL have ports a0, a1, a2 and a3, each output, 1 bit, registered: one-hot decoded lines.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a0..a3 carry a decoded value.
REQ-010 The block SHALL have port cnt_sel, input, 2 bits: event-counter select (see Configuration).
REQ-011 The block SHALL have port cnt_out, output, 8 bits: selected event counter value.

Function
REQ-012 The decode SHALL be: code 00->a0, 01->a1, 10->a2, 11->a3, with exactly one line high while out_valid=1.
REQ-013 The FSM SHALL have three states: IDLE, HOLD, GAP.
REQ-014 in_ready SHALL be 1 only in IDLE (combinational from state), and a handshake SHALL occur when in_valid=1 and in_ready=1 on a rising edge.
REQ-015 On a handshake at edge N, the block SHALL latch the code, enter HOLD and load hold_cnt=HOLD_CYCLES-1, and the decoded line and out_valid SHALL be high from edge N+1.
REQ-016 In HOLD, the block SHALL decrement hold_cnt each cycle, and when hold_cnt=0 it SHALL enter GAP if GAP_CYCLES>0 (loading gap_cnt=GAP_CYCLES-1), else IDLE.
REQ-017 Outputs a0..a3 and out_valid SHALL be high for exactly HOLD_CYCLES cycles per accepted code; HOLD_CYCLES=1 gives a single-cycle pulse.
REQ-018 In GAP, a0..a3 and out_valid SHALL be 0, gap_cnt SHALL decrement, and the FSM SHALL return to IDLE when gap_cnt=0.
REQ-019 in_valid, y0 and y1 SHALL be ignored outside IDLE; the latched code SHALL NOT change during HOLD or GAP.
REQ-020 With GAP_CYCLES=0, back-to-back codes SHALL be accepted on the edge immediately after the last HOLD cycle, giving a minimum code period of HOLD_CYCLES+1 cycles.
REQ-021 In IDLE, a0..a3 and out_valid SHALL be 0.

Reset
REQ-022 When rst=1 at a rising edge, the FSM SHALL go to IDLE, a0..a3=0, out_valid=0, the counters SHALL be cleared and the latched code SHALL be 00.
REQ-023 rst SHALL have priority over a simultaneous handshake, and a hold or gap in progress SHALL be aborted without completing.
REQ-024 in_ready SHALL be 1 on the first cycle after reset deassertion.

Configuration
REQ-025 When the macro DECODER24_CNT_EN is defined, the block SHALL keep four 8-bit saturating event counters, one per output line, each incremented on the handshake for its code; cnt_out SHALL equal counter[cnt_sel] combinationally, and rst SHALL clear the counters.
REQ-026 When DECODER24_CNT_EN is undefined, the block SHALL contain no counters, cnt_out SHALL be constant 0 and cnt_sel SHALL be unused.

Verification
REQ-027 The bench SHALL cover: reset, then in_valid=1 with code 10 held for 1 cycle -> a2=1 and out_valid=1 for 4 cycles starting the next cycle, 1 gap cycle, then in_ready=1.
REQ-028 The bench SHALL cover: all four codes 00, 01, 10, 11 sequentially -> a0, a1, a2, a3 respectively, one-hot only, with never two lines high.
REQ-029 The bench SHALL cover: HOLD_CYCLES=1 and GAP_CYCLES=0 with in_valid held high and code 11 -> a3 pulses 1 cycle high, 1 cycle low, repeating.
REQ-030 The bench SHALL cover: changing y1,y0 from 01 to 11 during HOLD -> a1 stays asserted and a3 stays 0.
REQ-031 The bench SHALL cover: rst=1 asserted in the 2nd HOLD cycle -> all outputs 0 next cycle, then in_ready=1 after rst deasserts.
REQ-032 The bench SHALL cover, with DECODER24_CNT_EN defined: 300 handshakes of code 01 -> with cnt_sel=01, cnt_out=255 (saturated), and with cnt_sel=00, cnt_out=0.
